// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W  = 16;
    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_MEM_LAT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IF   = 2'd1,
        ST_D    = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// Access latency counter: loads MEM_LAT-1 on grant, counts down while busy,
// and flags zero on the final cycle of the access.
module lat_counter #(
    parameter int unsigned MEM_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT) + 1;

    logic [CNT_W-1:0] r_cnt;

    // Load on grant, otherwise decrement until zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(MEM_LAT - 1);
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between the fetch port
// and the data port. Data has fixed priority; one access in flight at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned MEM_LAT = DEF_MEM_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_re,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              hlt,
    output logic              halted,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic              r_if_ack;
    logic              r_d_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_halted;
    logic              r_mem_re;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic w_d_go;
    logic w_if_go;
    logic w_cnt_zero;
    logic w_grant_d;
    logic w_grant_if;
    logic w_done_if;
    logic w_done_d;
    logic w_cnt_load;
    logic w_cnt_dec;

    // A port whose ack is high this cycle is still holding its old request
    assign w_d_go  = (d_re | d_we) & ~r_d_ack;
    assign w_if_go = if_req & ~r_if_ack & ~hlt;

    lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_cnt_load),
        .i_dec  (w_cnt_dec),
        .o_zero (w_cnt_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: grant from IDLE, return to IDLE when the counter expires
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_d_go) begin
                    w_state_nxt = ST_D;
                end else if (w_if_go) begin
                    w_state_nxt = ST_IF;
                end
            end
            ST_IF, ST_D: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: grant and completion strobes, counter control
    always_comb begin
        w_grant_d  = (r_state == ST_IDLE) & w_d_go;
        w_grant_if = (r_state == ST_IDLE) & ~w_d_go & w_if_go;
        w_done_if  = (r_state == ST_IF) & w_cnt_zero;
        w_done_d   = (r_state == ST_D) & w_cnt_zero;
        w_cnt_load = w_grant_d | w_grant_if;
        w_cnt_dec  = (r_state == ST_IF) | (r_state == ST_D);
    end

    // Registered memory interface, acks and read data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_ack    <= 1'b0;
            r_d_ack     <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_halted    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_if_ack <= w_done_if;
            r_d_ack  <= w_done_d;
            r_halted <= hlt & (r_state == ST_IDLE);
            if (w_grant_d) begin
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
                r_mem_we    <= d_we;
                r_mem_re    <= ~d_we;
            end else if (w_grant_if) begin
                r_mem_addr <= if_addr;
                r_mem_we   <= 1'b0;
                r_mem_re   <= 1'b1;
            end
            if (w_done_if) begin
                r_if_rdata <= mem_rdata;
            end
            if (w_done_d && !r_mem_we) begin
                r_d_rdata <= mem_rdata;
            end
            if (w_done_if || w_done_d) begin
                r_mem_re <= 1'b0;
                r_mem_we <= 1'b0;
            end
        end
    end

    assign if_ack    = r_if_ack;
    assign d_ack     = r_d_ack;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign halted    = r_halted;
    assign mem_re    = r_mem_re;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a transaction-level model.
module tb_mem_arbiter;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        d_re;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        hlt;
    logic        halted;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int n_total = 0;
    int n_bad   = 0;

    mem_arbiter #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .MEM_LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_re      (d_re),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .hlt       (hlt),
        .halted    (halted),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(int i);
        logic [7:0] b;
        b = 8'(i);
        if (i == 16) return 16'hA5A5;
        return {b ^ 8'h3C, b};
    endfunction

    // Fixed-latency RAM: read data is only valid on the last cycle of the access
    logic [15:0] phys_mem [256];
    logic        init_mem;
    int          re_cnt = 0;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) phys_mem[i] <= init_val(i);
        end else if (mem_we) begin
            phys_mem[mem_addr[7:0]] <= mem_wdata;
        end
        if (mem_re) re_cnt <= re_cnt + 1;
        else        re_cnt <= 0;
    end

    assign mem_rdata = (mem_re && re_cnt == LAT - 1) ? phys_mem[mem_addr[7:0]] : 16'hDEAD;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: one outstanding access, ack MEM_LAT+1 cycles after grant
    logic [15:0] ref_mem [256];
    int          m_owner;   // 0 none, 1 fetch, 2 data
    int          m_left;
    logic        m_write;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic        e_if_ack, e_d_ack, e_halted, e_mem_re, e_mem_we;
    logic [15:0] e_if_rdata, e_d_rdata, e_mem_addr, e_mem_wdata;

    task automatic model_reset();
        m_owner = 0; m_left = 0; m_write = 0; m_addr = '0; m_wdata = '0;
        e_if_ack = 0; e_d_ack = 0; e_halted = 0; e_mem_re = 0; e_mem_we = 0;
        e_if_rdata = '0; e_d_rdata = '0; e_mem_addr = '0; e_mem_wdata = '0;
    endtask

    task automatic model_step();
        logic n_if_ack, n_d_ack;
        n_if_ack = 0;
        n_d_ack  = 0;
        e_halted = hlt && (m_owner == 0);
        if (m_owner != 0) begin
            m_left--;
            if (m_left == 0) begin
                if (m_owner == 1) begin
                    e_if_rdata = ref_mem[m_addr[7:0]];
                    n_if_ack   = 1;
                end else begin
                    if (m_write) ref_mem[m_addr[7:0]] = m_wdata;
                    else         e_d_rdata = ref_mem[m_addr[7:0]];
                    n_d_ack = 1;
                end
                m_owner  = 0;
                e_mem_re = 0;
                e_mem_we = 0;
            end
        end else if ((d_re || d_we) && !e_d_ack) begin
            m_owner = 2; m_left = LAT; m_write = d_we; m_addr = d_addr; m_wdata = d_wdata;
            e_mem_re = !d_we; e_mem_we = d_we; e_mem_addr = d_addr; e_mem_wdata = d_wdata;
        end else if (if_req && !e_if_ack && !hlt) begin
            m_owner = 1; m_left = LAT; m_write = 0; m_addr = if_addr;
            e_mem_re = 1; e_mem_we = 0; e_mem_addr = if_addr;
        end
        e_if_ack = n_if_ack;
        e_d_ack  = n_d_ack;
    endtask

    typedef struct {
        logic        re;
        logic        we;
        logic        ifr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        exp_d;
        logic        exp_re;
        logic        exp_we;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vt [7];

    task automatic drive_idle();
        if_req = 0; if_addr = '0; d_re = 0; d_we = 0; d_addr = '0; d_wdata = '0; hlt = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".if_ack"},    {31'd0, if_ack}, 0);
        chk({tag, ".d_ack"},     {31'd0, d_ack},  0);
        chk({tag, ".if_rdata"},  {16'd0, if_rdata}, 0);
        chk({tag, ".d_rdata"},   {16'd0, d_rdata},  0);
        chk({tag, ".halted"},    {31'd0, halted}, 0);
        chk({tag, ".mem_re"},    {31'd0, mem_re}, 0);
        chk({tag, ".mem_we"},    {31'd0, mem_we}, 0);
        chk({tag, ".mem_addr"},  {16'd0, mem_addr},  0);
        chk({tag, ".mem_wdata"}, {16'd0, mem_wdata}, 0);
    endtask

    initial begin
        int lat, lat2, act, acks, wrong, cnt1, cnt2;
        logic if_drop, d_drop;
        int kind;

        vt[0] = '{1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hA5A5};
        vt[1] = '{1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1C20};
        vt[2] = '{1'b0, 1'b1, 1'b0, 16'h0030, 16'h1234, 1'b1, 1'b0, 1'b1, 16'h1C20};
        vt[3] = '{1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1234};
        vt[4] = '{1'b1, 1'b1, 1'b0, 16'h0040, 16'hBEEF, 1'b1, 1'b0, 1'b1, 16'h1234};
        vt[5] = '{1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hBEEF};
        vt[6] = '{1'b0, 1'b0, 1'b1, 16'h0030, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h1234};

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

        drive_idle();
        rst = 1;
        init_mem = 1;
        @(negedge clk);
        init_mem = 0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 0;
        @(negedge clk);

        // Single accesses from idle
        for (int v = 0; v < 7; v++) begin
            d_re = vt[v].re; d_we = vt[v].we; if_req = vt[v].ifr;
            d_addr = vt[v].addr; if_addr = vt[v].addr; d_wdata = vt[v].wdata;
            lat = 0; act = 0; acks = 0; wrong = 0;
            for (int n = 1; n <= 12; n++) begin
                @(negedge clk);
                if (n == 1) begin
                    chk($sformatf("vec%0d.mem_re", v),   {31'd0, mem_re}, {31'd0, vt[v].exp_re});
                    chk($sformatf("vec%0d.mem_we", v),   {31'd0, mem_we}, {31'd0, vt[v].exp_we});
                    chk($sformatf("vec%0d.mem_addr", v), {16'd0, mem_addr}, {16'd0, vt[v].addr});
                end
                if (mem_re || mem_we) act++;
                if (vt[v].exp_d ? d_ack : if_ack) begin
                    acks++;
                    if (lat == 0) begin
                        lat = n;
                        chk($sformatf("vec%0d.rdata", v),
                            {16'd0, (vt[v].exp_d ? d_rdata : if_rdata)}, {16'd0, vt[v].exp_rdata});
                        d_re = 0; d_we = 0; if_req = 0;
                    end
                end
                if (vt[v].exp_d ? if_ack : d_ack) wrong++;
            end
            chk($sformatf("vec%0d.latency", v), lat, LAT + 1);
            chk($sformatf("vec%0d.busy_cycles", v), act, LAT);
            chk($sformatf("vec%0d.ack_count", v), acks, 1);
            chk($sformatf("vec%0d.other_ack", v), wrong, 0);
        end

        // Simultaneous data and fetch: data first, fetch granted in the d_ack cycle
        d_re = 1; d_addr = 16'h0020; if_req = 1; if_addr = 16'h0010;
        lat = 0; lat2 = 0; cnt1 = 0; cnt2 = 0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (lat != 0 && n > lat) d_re = 0;
            if (lat2 != 0 && n > lat2) if_req = 0;
            if (d_ack) begin
                cnt1++;
                if (lat == 0) begin lat = n; chk("both.d_rdata", {16'd0, d_rdata}, 32'h1C20); end
            end
            if (if_ack) begin
                cnt2++;
                if (lat2 == 0) begin lat2 = n; chk("both.if_rdata", {16'd0, if_rdata}, 32'hA5A5); end
            end
        end
        chk("both.d_latency", lat, 5);
        chk("both.if_latency", lat2, 10);
        chk("both.d_ack_count", cnt1, 1);
        chk("both.if_ack_count", cnt2, 1);
        drive_idle();
        @(negedge clk);

        // Halt raised during a fetch: fetch completes, later fetches blocked, data served
        if_req = 1; if_addr = 16'h0010;
        lat = 0;
        for (int n = 1; n <= 12 && lat == 0; n++) begin
            @(negedge clk);
            if (if_ack) begin
                lat = n;
                chk("hlt.if_rdata", {16'd0, if_rdata}, 32'hA5A5);
                chk("hlt.halted_in_ack", {31'd0, halted}, 0);
            end
            if (n == 2) hlt = 1;
        end
        chk("hlt.if_latency", lat, 5);
        @(negedge clk);
        chk("hlt.halted_after", {31'd0, halted}, 1);
        if_addr = 16'h0030;
        cnt1 = 0; cnt2 = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (if_ack) cnt1++;
            if (mem_re) cnt2++;
        end
        chk("hlt.blocked_ack", cnt1, 0);
        chk("hlt.blocked_mem_re", cnt2, 0);
        chk("hlt.halted_held", {31'd0, halted}, 1);
        d_re = 1; d_addr = 16'h0030;
        lat = 0; cnt1 = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (d_ack && lat == 0) begin
                lat = n;
                chk("hlt.d_rdata", {16'd0, d_rdata}, 32'h1234);
                d_re = 0;
            end
            if (if_ack) cnt1++;
        end
        chk("hlt.d_latency", lat, 5);
        chk("hlt.if_during_d", cnt1, 0);
        hlt = 0;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (if_ack && lat == 0) begin
                lat = n;
                chk("unhlt.if_rdata", {16'd0, if_rdata}, 32'h1234);
                if_req = 0;
            end
        end
        chk("unhlt.if_latency", lat, 5);
        drive_idle();
        @(negedge clk);

        // Reset two cycles into a data access abandons it
        d_re = 1; d_addr = 16'h0020;
        @(negedge clk);
        @(negedge clk);
        rst = 1; d_re = 0;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 0;
        cnt1 = 0; cnt2 = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (d_ack) cnt1++;
            if (mem_re || mem_we) cnt2++;
        end
        chk("midrst.no_ack", cnt1, 0);
        chk("midrst.no_mem", cnt2, 0);
        d_re = 1; d_addr = 16'h0020;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (d_ack && lat == 0) begin
                lat = n;
                chk("midrst.re_rdata", {16'd0, d_rdata}, 32'h1C20);
                d_re = 0;
            end
        end
        chk("midrst.re_latency", lat, 5);
        drive_idle();

        // Random traffic against the model, from a fresh reset
        ref_mem[16'h30] = 16'h1234;
        ref_mem[16'h40] = 16'hBEEF;
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
        if_drop = 0; d_drop = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("rnd.if_ack",   {31'd0, if_ack},   {31'd0, e_if_ack});
            chk("rnd.d_ack",    {31'd0, d_ack},    {31'd0, e_d_ack});
            chk("rnd.if_rdata", {16'd0, if_rdata}, {16'd0, e_if_rdata});
            chk("rnd.d_rdata",  {16'd0, d_rdata},  {16'd0, e_d_rdata});
            chk("rnd.mem_re",   {31'd0, mem_re},   {31'd0, e_mem_re});
            chk("rnd.mem_we",   {31'd0, mem_we},   {31'd0, e_mem_we});
            chk("rnd.halted",   {31'd0, halted},   {31'd0, e_halted});
            if (e_mem_re || e_mem_we)
                chk("rnd.mem_addr", {16'd0, mem_addr}, {16'd0, e_mem_addr});
            if (e_mem_we)
                chk("rnd.mem_wdata", {16'd0, mem_wdata}, {16'd0, e_mem_wdata});

            if (if_drop) begin
                if_drop = 0;
                if_req  = ($urandom_range(0, 1) == 1);
                if_addr = 16'($urandom_range(0, 63));
            end else if (if_ack) begin
                if_drop = 1;
            end else if (!if_req && $urandom_range(0, 3) == 0) begin
                if_req  = 1;
                if_addr = 16'($urandom_range(0, 63));
            end

            if (d_drop || (!d_re && !d_we && $urandom_range(0, 3) == 0)) begin
                if (d_drop && $urandom_range(0, 1) == 0) begin
                    d_re = 0; d_we = 0;
                end else begin
                    kind    = int'($urandom_range(0, 2));
                    d_we    = (kind != 0);
                    d_re    = (kind != 1);
                    d_addr  = 16'($urandom_range(0, 63));
                    d_wdata = 16'($urandom);
                end
                d_drop = 0;
            end else if (d_ack) begin
                d_drop = 1;
            end

            if ($urandom_range(0, 39) == 0) hlt = ~hlt;
            model_step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
